// File: rtl/updown_seq_pkg.sv
// Shared types for the up/down counter sequencer: state encoding, mode values, step direction.
// Pure declarations; no latency or backpressure of its own.
package updown_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // Signed unit step; callers size-cast it, which sign-extends -1 to all ones.
    function automatic logic signed [1:0] step(input logic mode);
        return (mode == MODE_UP) ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/updown_seq_watchdog.sv
// Counts consecutive cycles with run high; expire is high during the LIMIT-th such cycle.
// Output is combinational from the count, no backpressure; dropping run clears the count.
module updown_seq_watchdog #(
    parameter int unsigned LIMIT = 260
) (
    input  logic clk,
    input  logic clr_n,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire = run && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (!expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_counter_sequencer.sv
// Loads start into the up/down counter, runs it to target, parks it; done = |target-start|+2 from transfer cycle.
// Accepts one command at a time (cmd_ready only in IDLE); watchdog under SEQ_TIMEOUT_EN.
module updown_counter_sequencer
    import updown_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 260
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             abort,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             ctr_mode,
    output logic             ctr_ld,
    output logic [WIDTH-1:0] ctr_d_in,
    output logic             ctr_clr,
    output logic             done,
    output logic             timeout
);

    if (TIMEOUT_CYC <= 2 ** WIDTH) begin : g_cfg_check
        $error("TIMEOUT_CYC must exceed 2**WIDTH");
    end

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] park_q, park_d;
    logic             mode_q, mode_d;

    logic             ld_q, ld_d;
    logic [WIDTH-1:0] d_in_q, d_in_d;
    logic             clr_q;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic             transfer;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] next_cnt;
    logic             match;
    logic             wd_expire;

    assign transfer = cmd_valid && ready_q;
    assign step_w   = WIDTH'(step(mode_q));
    assign next_cnt = ctr_count + step_w;
    // Matching one step early lets the counter land on target at the same edge we enter DONE.
    assign match    = (ctr_count == (target_q - step_w));

`ifdef SEQ_TIMEOUT_EN
    updown_seq_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .clr_n  (clr_n),
        .run    (state_q == ST_RUN),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            target_q  <= '0;
            park_q    <= '0;
            mode_q    <= MODE_UP;
            ld_q      <= 1'b1;
            d_in_q    <= '0;
            clr_q     <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            target_q  <= target_d;
            park_q    <= park_d;
            mode_q    <= mode_d;
            ld_q      <= ld_d;
            d_in_q    <= d_in_d;
            clr_q     <= 1'b0;
            ready_q   <= ready_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        target_d  = target_q;
        park_d    = park_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    start_d  = cmd_start;
                    target_d = cmd_target;
                    mode_d   = (cmd_target >= cmd_start) ? MODE_UP : MODE_DOWN;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    park_d  = start_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = (start_q == target_q) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Park wherever the counter lands on this edge so IDLE holds it still.
                if (abort) begin
                    park_d  = next_cnt;
                    state_d = ST_IDLE;
                end else if (match) begin
                    state_d = ST_DONE;
                end else if (wd_expire) begin
                    park_d    = next_cnt;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: begin
                park_d  = target_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ld_d    = (state_d != ST_RUN);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        d_in_d  = d_in_q;
        case (state_d)
            ST_IDLE: d_in_d = park_d;
            ST_LOAD: d_in_d = start_d;
            ST_DONE: d_in_d = target_d;
            default: d_in_d = d_in_q;
        endcase
    end

    assign cmd_ready = ready_q;
    assign ctr_mode  = mode_q;
    assign ctr_ld    = ld_q;
    assign ctr_d_in  = d_in_q;
    assign ctr_clr   = clr_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Sequencer driving a behavioural 8-bit up/down counter; done pulses checked against a scoreboard.
// The timeout scenario is compiled in when SEQ_TIMEOUT_EN is defined.
module tb_updown_counter_sequencer;

    localparam int unsigned TO_CYC = 260;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_target;
    logic       abort;
    logic [7:0] ctr_count;
    logic       ctr_mode;
    logic       ctr_ld;
    logic [7:0] ctr_d_in;
    logic       ctr_clr;
    logic       done;
    logic       timeout;
    logic       ext_clr;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tcyc = 0;
    int   to_seen = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Up/down counter: synchronous clear over load over step.
    always @(posedge clk) begin
        if (ctr_clr || ext_clr)  ctr_count <= 8'h00;
        else if (ctr_ld)         ctr_count <= ctr_d_in;
        else if (ctr_mode)       ctr_count <= ctr_count + 8'd1;
        else                     ctr_count <= ctr_count - 8'd1;
    end

    updown_counter_sequencer #(
        .WIDTH       (8),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_target (cmd_target),
        .abort      (abort),
        .ctr_count  (ctr_count),
        .ctr_mode   (ctr_mode),
        .ctr_ld     (ctr_ld),
        .ctr_d_in   (ctr_d_in),
        .ctr_clr    (ctr_clr),
        .done       (done),
        .timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n === 1'b1 && done === 1'b1) begin
            chk("done_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_count", ctr_count, mon_e.val);
            end
        end
        if (timeout === 1'b1) to_seen++;
    end

    task automatic send(input logic [7:0] s, input logic [7:0] t, input bit want_done);
        int   n;
        int   d;
        exp_t e;
        n = 0;
        d = (t >= s) ? int'(t) - int'(s) : int'(s) - int'(t);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_start  = s;
        cmd_target = t;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", cmd_ready, 1);
        tcyc = cyc;
        if (want_done) begin
            e.cyc = cyc + d + 2;
            e.val = t;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_start  = 8'($urandom);
        cmd_target = 8'($urandom);
    endtask

    // Called right after send(): checks LOAD, then the count in every cycle through DONE.
    task automatic track(input logic [7:0] s, input logic [7:0] t);
        int         d;
        logic       up;
        logic [7:0] v;
        up = (t >= s);
        d  = up ? int'(t) - int'(s) : int'(s) - int'(t);
        @(negedge clk);
        chk("load_ld", ctr_ld, 1);
        chk("load_d_in", ctr_d_in, s);
        chk("load_mode", ctr_mode, up);
        v = s;
        for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            chk("run_count", ctr_count, v);
            if (d == 0) chk("equal_no_run_ld", ctr_ld, 1);
            v = up ? v + 8'd1 : v - 8'd1;
        end
        chk("done_mode", ctr_mode, up);
    endtask

    initial begin
        int         n;
        int         at;
        logic [7:0] prev;
        clr_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_start  = 8'h00;
        cmd_target = 8'h00;
        abort      = 1'b0;
        ext_clr    = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_clr", ctr_clr, 1);
        chk("rst_ld", ctr_ld, 1);
        chk("rst_d_in", ctr_d_in, 0);
        chk("rst_mode", ctr_mode, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_count", ctr_count, 0);
        clr_n = 1'b1;
        #1;
        chk("clr_until_edge", ctr_clr, 1);
        @(negedge clk);
        chk("clr_drop", ctr_clr, 0);
        chk("ready_rise", cmd_ready, 1);
        repeat (5) @(negedge clk);
        chk("idle_count", ctr_count, 0);

        // Up
        send(8'h05, 8'h0A, 1'b1);
        track(8'h05, 8'h0A);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("up_hold", ctr_count, 8'h0A);
        end

        // Down
        send(8'h10, 8'h0C, 1'b1);
        track(8'h10, 8'h0C);
        repeat (5) @(negedge clk);
        chk("down_hold", ctr_count, 8'h0C);

        // Equal and full range
        send(8'h80, 8'h80, 1'b1);
        track(8'h80, 8'h80);
        send(8'h00, 8'hFF, 1'b1);
        track(8'h00, 8'hFF);
        @(negedge clk);
        chk("full_hold", ctr_count, 8'hFF);

        // Abort in RUN
        send(8'h00, 8'h40, 1'b0);
        n = 0;
        @(negedge clk);
        while (ctr_count !== 8'h12 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", ctr_count, 8'h12);
        chk("abort_mode", ctr_mode, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_park", ctr_count, 8'h13);
        chk("abort_d_in", ctr_d_in, 8'h13);
        repeat (10) @(negedge clk);
        chk("abort_hold", ctr_count, 8'h13);

        // Abort in LOAD
        send(8'h20, 8'h30, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_load_ready", cmd_ready, 1);
        chk("abort_load_park", ctr_count, 8'h20);
        repeat (3) @(negedge clk);
        chk("abort_load_hold", ctr_count, 8'h20);

        // Abort in IDLE is ignored
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_ready", cmd_ready, 1);
        chk("abort_idle_count", ctr_count, 8'h20);

        // Reset mid-run
        send(8'hF0, 8'h10, 1'b0);
        repeat (10) @(negedge clk);
        chk("midrun_mode", ctr_mode, 0);
        clr_n = 1'b0;
        #1;
        chk("midrun_rst_clr", ctr_clr, 1);
        chk("midrun_rst_ready", cmd_ready, 0);
        chk("midrun_rst_ld", ctr_ld, 1);
        chk("midrun_rst_mode", ctr_mode, 1);
        chk("midrun_rst_d_in", ctr_d_in, 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrun_recover_ready", cmd_ready, 1);
        chk("midrun_recover_count", ctr_count, 0);

`ifdef SEQ_TIMEOUT_EN
        // Counter cleared behind the sequencer's back never arrives
        send(8'h00, 8'hFF, 1'b0);
        at   = -1;
        prev = 8'h00;
        for (int k = 0; k < 400 && at < 0; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                at = cyc;
                chk("timeout_park", ctr_count, prev + 8'd1);
                chk("timeout_ready", cmd_ready, 1);
            end
            prev    = ctr_count;
            ext_clr = ((k % 50) == 49);
        end
        ext_clr = 1'b0;
        chk("timeout_cycle", at, tcyc + TO_CYC + 2);
        @(negedge clk);
        chk("timeout_one_cycle", timeout, 0);
        chk("timeout_to_seen", to_seen, 1);
`else
        at   = 0;
        prev = 8'h00;
        chk("timeout_to_seen", to_seen + at + int'(prev), 0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
